uart2bus_top: RTL and testbench

UART-to-register-bus bridge: receives binary command packets on a 115200-baud 8N1 serial line and converts them into single-cycle read/write strobes on an 8-bit internal register bus. Read data and optional acknowledge bytes are returned on the serial output. It sits between an external host UART and an on-chip register file such as `reg_file_model`.

---
 rtl/uart2bus_top.sv | 242 ++++++++++++++++++++++++
 tb/tb_uart2bus_top.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart2bus_top.sv
// UART-to-register-bus bridge: 8N1 serial command packets become single-cycle
// read/write strobes on an 8-bit register bus; read data and acks go back out.
module uart2bus_top #(
   parameter int CLK_FREQ = 40000000,
   parameter int BAUD     = 115200
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       ser_in,
   output logic       ser_out,
   output logic [7:0] int_address,
   output logic [7:0] int_wr_data,
   output logic       int_write,
   output logic       int_read,
   input  logic [7:0] int_rd_data
);
   localparam logic [31:0] INC  = 32'(16 * BAUD);
   localparam logic [31:0] FREQ = 32'(CLK_FREQ);

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic [3:0] {P_IDLE, P_CMD, P_ADDR_H, P_ADDR_L, P_LEN, P_WR_DATA,
                             P_RD_ISSUE, P_RD_WAIT, P_RD_SEND, P_ACK} p_state_t;

   logic [31:0] acc_q, acc_d, acc_sum;
   logic        baud_tick;

   logic        sync1_q, sync2_q, prev_q;
   rx_state_t   rx_state_q, rx_state_d;
   logic [3:0]  rx_tick_q, rx_tick_d;
   logic [2:0]  rx_bit_q, rx_bit_d;
   logic [7:0]  rx_shift_q, rx_shift_d;
   logic        rx_valid;

   logic        tx_busy_q, tx_busy_d, tx_start, ser_out_q;
   logic [9:0]  tx_shift_q, tx_shift_d;
   logic [3:0]  tx_tick_q, tx_tick_d, tx_bit_q, tx_bit_d;
   logic [7:0]  tx_byte;

   p_state_t    p_state_q, p_state_d;
   logic [7:0]  cmd_q, cmd_d, ptr_q, ptr_d, rd_q, rd_d, step;
   logic [8:0]  len_q, len_d;
   logic        phase_q, phase_d;
   logic [7:0]  addr_out_q, addr_out_d, wdata_q, wdata_d;
   logic        write_q, write_d, read_q, read_d;

   // Fractional accumulator yields a 16x oversample tick with no long-term drift
   always_comb begin
      acc_sum   = acc_q + INC;
      baud_tick = (acc_sum >= FREQ);
      acc_d     = baud_tick ? (acc_sum - FREQ) : acc_sum;
   end

   always_comb begin
      rx_state_d = rx_state_q;
      rx_tick_d  = rx_tick_q;
      rx_bit_d   = rx_bit_q;
      rx_shift_d = rx_shift_q;
      rx_valid   = 1'b0;
      if (baud_tick) rx_tick_d = rx_tick_q + 4'd1;
      case (rx_state_q)
         RX_IDLE: begin
            rx_tick_d = 4'd0;
            if (prev_q && !sync2_q) rx_state_d = RX_START;
         end
         RX_START: if (baud_tick && rx_tick_q == 4'd7) begin
            rx_tick_d  = 4'd0;
            rx_bit_d   = 3'd0;
            rx_state_d = sync2_q ? RX_IDLE : RX_DATA;
         end
         RX_DATA: if (baud_tick && rx_tick_q == 4'd15) begin
            rx_tick_d  = 4'd0;
            rx_shift_d = {sync2_q, rx_shift_q[7:1]};
            rx_bit_d   = rx_bit_q + 3'd1;
            if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
         end
         default: if (baud_tick && rx_tick_q == 4'd15) begin
            rx_valid   = sync2_q;
            rx_state_d = RX_IDLE;
         end
      endcase
   end

   always_comb begin
      tx_busy_d  = tx_busy_q;
      tx_shift_d = tx_shift_q;
      tx_tick_d  = tx_tick_q;
      tx_bit_d   = tx_bit_q;
      if (!tx_busy_q) begin
         if (tx_start) begin
            tx_busy_d  = 1'b1;
            tx_shift_d = {1'b1, tx_byte, 1'b0};
            tx_tick_d  = 4'd0;
            tx_bit_d   = 4'd0;
         end
      end else if (baud_tick) begin
         tx_tick_d = tx_tick_q + 4'd1;
         if (tx_tick_q == 4'd15) begin
            tx_tick_d  = 4'd0;
            tx_shift_d = {1'b1, tx_shift_q[9:1]};
            tx_bit_d   = tx_bit_q + 4'd1;
            if (tx_bit_q == 4'd9) tx_busy_d = 1'b0;
         end
      end
   end

   // Packet parser; phase_q marks "byte handed to TX" or "read strobe already seen"
   always_comb begin
      p_state_d  = p_state_q;
      cmd_d      = cmd_q;
      ptr_d      = ptr_q;
      rd_d       = rd_q;
      len_d      = len_q;
      phase_d    = phase_q;
      addr_out_d = addr_out_q;
      wdata_d    = wdata_q;
      write_d    = 1'b0;
      read_d     = 1'b0;
      tx_start   = 1'b0;
      tx_byte    = rd_q;
      step       = cmd_q[1] ? 8'd0 : 8'd1;
      case (p_state_q)
         P_IDLE: if (rx_valid && rx_shift_q == 8'h00) p_state_d = P_CMD;
         P_CMD: if (rx_valid) begin
            cmd_d   = rx_shift_q;
            phase_d = 1'b0;
            if (rx_shift_q[5:4] == 2'b01 || rx_shift_q[5:4] == 2'b10) p_state_d = P_ADDR_H;
            else p_state_d = rx_shift_q[0] ? P_ACK : P_IDLE;
         end
         P_ADDR_H: if (rx_valid) p_state_d = P_ADDR_L;
         P_ADDR_L: if (rx_valid) begin
            ptr_d     = rx_shift_q;
            p_state_d = P_LEN;
         end
         P_LEN: if (rx_valid) begin
            len_d     = {rx_shift_q == 8'h00, rx_shift_q};
            p_state_d = (cmd_q[5:4] == 2'b10) ? P_WR_DATA : P_RD_ISSUE;
         end
         P_WR_DATA: if (rx_valid) begin
            write_d    = 1'b1;
            addr_out_d = ptr_q;
            wdata_d    = rx_shift_q;
            ptr_d      = ptr_q + step;
            len_d      = len_q - 9'd1;
            phase_d    = 1'b0;
            if (len_q == 9'd1) p_state_d = cmd_q[0] ? P_ACK : P_IDLE;
         end
         P_RD_ISSUE: begin
            read_d     = 1'b1;
            addr_out_d = ptr_q;
            phase_d    = 1'b0;
            p_state_d  = P_RD_WAIT;
         end
         P_RD_WAIT: begin
            phase_d = 1'b1;
            if (phase_q) begin
               rd_d      = int_rd_data;
               phase_d   = 1'b0;
               p_state_d = P_RD_SEND;
            end
         end
         P_RD_SEND: begin
            if (!phase_q) begin
               tx_start = !tx_busy_q;
               phase_d  = !tx_busy_q;
            end else if (!tx_busy_q) begin
               ptr_d     = ptr_q + step;
               len_d     = len_q - 9'd1;
               phase_d   = 1'b0;
               p_state_d = (len_q == 9'd1) ? (cmd_q[0] ? P_ACK : P_IDLE) : P_RD_ISSUE;
            end
         end
         default: begin
            tx_byte = 8'h5A;
            if (!phase_q) begin
               tx_start = !tx_busy_q;
               phase_d  = !tx_busy_q;
            end else if (!tx_busy_q) begin
               phase_d   = 1'b0;
               p_state_d = P_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         acc_q      <= '0;
         sync1_q    <= 1'b1;
         sync2_q    <= 1'b1;
         prev_q     <= 1'b1;
         rx_state_q <= RX_IDLE;
         rx_tick_q  <= '0;
         rx_bit_q   <= '0;
         rx_shift_q <= '0;
         tx_busy_q  <= 1'b0;
         tx_shift_q <= '1;
         tx_tick_q  <= '0;
         tx_bit_q   <= '0;
         ser_out_q  <= 1'b1;
         p_state_q  <= P_IDLE;
         cmd_q      <= '0;
         ptr_q      <= '0;
         rd_q       <= '0;
         len_q      <= '0;
         phase_q    <= 1'b0;
         addr_out_q <= '0;
         wdata_q    <= '0;
         write_q    <= 1'b0;
         read_q     <= 1'b0;
      end else begin
         acc_q      <= acc_d;
         sync1_q    <= ser_in;
         sync2_q    <= sync1_q;
         prev_q     <= sync2_q;
         rx_state_q <= rx_state_d;
         rx_tick_q  <= rx_tick_d;
         rx_bit_q   <= rx_bit_d;
         rx_shift_q <= rx_shift_d;
         tx_busy_q  <= tx_busy_d;
         tx_shift_q <= tx_shift_d;
         tx_tick_q  <= tx_tick_d;
         tx_bit_q   <= tx_bit_d;
         ser_out_q  <= tx_busy_d ? tx_shift_d[0] : 1'b1;
         p_state_q  <= p_state_d;
         cmd_q      <= cmd_d;
         ptr_q      <= ptr_d;
         rd_q       <= rd_d;
         len_q      <= len_d;
         phase_q    <= phase_d;
         addr_out_q <= addr_out_d;
         wdata_q    <= wdata_d;
         write_q    <= write_d;
         read_q     <= read_d;
      end
   end

   assign ser_out     = ser_out_q;
   assign int_address = addr_out_q;
   assign int_wr_data = wdata_q;
   assign int_write   = write_q;
   assign int_read    = read_q;
endmodule

// File: tb/tb_uart2bus_top.sv
// Bench for uart2bus_top: serial packets in, bus strobes and serial replies checked
// against a packet-level model of the bridge and a shadow copy of the register file.
module tb_uart2bus_top;
   localparam int CLK_FREQ = 3686400;   // exactly 2 clocks per oversample tick
   localparam int BAUD     = 115200;
   localparam int BITCLK   = 32;

   logic       clock = 1'b0;
   logic       reset;
   logic       ser_in;
   logic       ser_out;
   logic [7:0] int_address, int_wr_data, int_rd_data;
   logic       int_write, int_read;

   always #5 clock = ~clock;

   uart2bus_top #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
      .clock(clock), .reset(reset), .ser_in(ser_in), .ser_out(ser_out),
      .int_address(int_address), .int_wr_data(int_wr_data),
      .int_write(int_write), .int_read(int_read), .int_rd_data(int_rd_data)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
   endtask

   // Register file with one-cycle read latency, seeded once from init_mem
   logic [7:0] init_mem [256];
   logic [7:0] regmem [256];
   logic       mem_loaded = 1'b0;
   always @(posedge clock) begin
      if (!mem_loaded) begin
         for (int i = 0; i < 256; i++) regmem[i] <= init_mem[i];
         mem_loaded  <= 1'b1;
         int_rd_data <= 8'h00;
      end else begin
         if (int_write) regmem[int_address] <= int_wr_data;
         if (int_read)  int_rd_data <= regmem[int_address];
      end
   end

   logic [15:0] obs_wr[$];
   logic [7:0]  obs_tx[$];
   int          n_reads, both_seen, stop_err;

   always @(negedge clock) begin
      if (reset === 1'b0) begin
         if (int_write) obs_wr.push_back({int_address, int_wr_data});
         if (int_read) n_reads++;
         if (int_write && int_read) both_seen++;
      end
   end

   logic [7:0] mon_d;
   initial begin
      forever begin
         @(negedge clock);
         if (ser_out === 1'b0) begin
            repeat (BITCLK / 2) @(negedge clock);
            for (int i = 0; i < 8; i++) begin
               repeat (BITCLK) @(negedge clock);
               mon_d[i] = ser_out;
            end
            repeat (BITCLK) @(negedge clock);
            if (ser_out !== 1'b1) stop_err++;
            obs_tx.push_back(mon_d);
         end
      end
   end

   // Packet-level reference model
   logic [7:0]  model_mem [256];
   logic [7:0]  pkt[$];
   logic [15:0] exp_wr[$];
   logic [7:0]  exp_tx[$];
   int          exp_reads;

   task automatic model_packet();
      int i, len;
      logic [7:0] cmd, addr, d;
      i = 0;
      while (i < pkt.size() && pkt[i] != 8'h00) i++;
      if (i + 1 >= pkt.size()) return;
      cmd = pkt[i+1];
      if (cmd[5:4] == 2'b01 || cmd[5:4] == 2'b10) begin
         addr = pkt[i+3];
         len  = (pkt[i+4] == 8'h00) ? 256 : int'(pkt[i+4]);
         for (int k = 0; k < len; k++) begin
            if (cmd[5:4] == 2'b10) begin
               d = pkt[i+5+k];
               exp_wr.push_back({addr, d});
               model_mem[addr] = d;
            end else begin
               exp_tx.push_back(model_mem[addr]);
               exp_reads++;
            end
            if (!cmd[1]) addr = addr + 8'd1;
         end
      end
      if (cmd[0]) exp_tx.push_back(8'h5A);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      @(negedge clock);
      ser_in = 1'b0;
      repeat (BITCLK) @(negedge clock);
      for (int i = 0; i < 8; i++) begin
         ser_in = b[i];
         repeat (BITCLK) @(negedge clock);
      end
      ser_in = stop_bit;
      repeat (BITCLK) @(negedge clock);
      if (!stop_bit) begin
         ser_in = 1'b1;
         repeat (BITCLK) @(negedge clock);
      end
   endtask

   task automatic glitch();
      ser_in = 1'b0;
      repeat (7) @(negedge clock);   // about 2 us at the nominal clock
      ser_in = 1'b1;
      repeat (2 * BITCLK) @(negedge clock);
   endtask

   task automatic clear_obs();
      obs_wr.delete();
      obs_tx.delete();
      n_reads   = 0;
      both_seen = 0;
      stop_err  = 0;
   endtask

   task automatic run_packet(input string name, input int bad_idx, input int glitch_idx);
      int n;
      exp_wr.delete();
      exp_tx.delete();
      exp_reads = 0;
      clear_obs();
      model_packet();
      for (int i = 0; i < pkt.size(); i++) begin
         if (i == bad_idx) send_byte(8'($urandom), 1'b0);
         if (i == glitch_idx) glitch();
         send_byte(pkt[i], 1'b1);
      end
      for (int c = 0; c < 20000 && obs_tx.size() < exp_tx.size(); c++) @(negedge clock);
      repeat (400) @(negedge clock);
      check({name, " wr_count"}, obs_wr.size(), exp_wr.size());
      n = (obs_wr.size() < exp_wr.size()) ? obs_wr.size() : exp_wr.size();
      for (int i = 0; i < n; i++) check($sformatf("%s wr%0d", name, i), obs_wr[i], exp_wr[i]);
      check({name, " tx_count"}, obs_tx.size(), exp_tx.size());
      n = (obs_tx.size() < exp_tx.size()) ? obs_tx.size() : exp_tx.size();
      for (int i = 0; i < n; i++) check($sformatf("%s tx%0d", name, i), obs_tx[i], exp_tx[i]);
      check({name, " reads"}, n_reads, exp_reads);
      check({name, " overlap"}, both_seen, 0);
      check({name, " tx_stop"}, stop_err, 0);
      $display("packet %s: %0d bytes in, %0d writes, %0d reads, %0d bytes out",
               name, pkt.size(), obs_wr.size(), n_reads, obs_tx.size());
   endtask

   task automatic check_reset_outputs(input string name);
      check({name, " ser_out"}, ser_out, 1'b1);
      check({name, " int_write"}, int_write, 1'b0);
      check({name, " int_read"}, int_read, 1'b0);
      check({name, " int_address"}, int_address, 8'h00);
      check({name, " int_wr_data"}, int_wr_data, 8'h00);
   endtask

   initial begin
      logic [7:0] v, cmd;
      logic [1:0] op;
      int         len, kind;
      for (int i = 0; i < 256; i++) begin
         v = 8'($urandom);
         init_mem[i]  = v;
         model_mem[i] = v;
      end
      clear_obs();
      reset  = 1'b1;
      ser_in = 1'b1;
      repeat (5) @(negedge clock);
      check_reset_outputs("reset");
      reset = 1'b0;
      repeat (2 * BITCLK) @(negedge clock);

      pkt = '{8'h00, 8'h20, 8'h00, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33};
      run_packet("write_ack", -1, -1);
      pkt = '{8'h00, 8'h11, 8'h00, 8'h10, 8'h03};
      run_packet("readback", -1, -1);
      pkt = '{8'h00, 8'h22, 8'h00, 8'h40, 8'h02, 8'hAA, 8'hBB};
      run_packet("noinc", -1, -1);
      pkt = '{8'h00, 8'h20, 8'h00, 8'hFF, 8'h02, 8'h01, 8'h02};
      run_packet("wrap", -1, -1);
      pkt = '{8'h00, 8'h01};
      run_packet("nop_ack", -1, -1);
      pkt = '{8'h55, 8'h00, 8'h20, 8'h00, 8'h50, 8'h01, 8'h77};
      run_packet("idle_noise", -1, -1);
      pkt = '{8'h00, 8'h21, 8'h00, 8'h60, 8'h02, 8'hC3, 8'h3C};
      run_packet("bad_stop", 5, -1);
      pkt = '{8'h00, 8'h20, 8'h00, 8'h70, 8'h02, 8'h5A, 8'hA5};
      run_packet("glitch", -1, 6);

      // Reset in the middle of a write burst, partway through a data byte
      clear_obs();
      pkt = '{8'h00, 8'h20, 8'h00, 8'h30, 8'h04, 8'hAA};
      for (int i = 0; i < pkt.size(); i++) send_byte(pkt[i], 1'b1);
      repeat (40) @(negedge clock);
      ser_in = 1'b0;
      repeat (48) @(negedge clock);
      reset = 1'b1;
      repeat (3) @(negedge clock);
      ser_in = 1'b1;
      check_reset_outputs("midreset");
      reset = 1'b0;
      repeat (4 * BITCLK) @(negedge clock);
      check("midreset wr_count", obs_wr.size(), 1);
      if (obs_wr.size() > 0) check("midreset wr0", obs_wr[0], 16'h30AA);
      check("midreset tx_count", obs_tx.size(), 0);
      model_mem[8'h30] = 8'hAA;
      $display("packet midreset: %0d writes before reset", obs_wr.size());
      pkt = '{8'h00, 8'h21, 8'h00, 8'h31, 8'h02, 8'h5C, 8'hC5};
      run_packet("after_reset", -1, -1);
      pkt = '{8'h00, 8'h10, 8'h00, 8'h30, 8'h03};
      run_packet("after_reset_rd", -1, -1);

      for (int p = 0; p < 8; p++) begin
         kind = $urandom_range(0, 2);
         len  = $urandom_range(1, 3);
         op   = (kind == 0) ? 2'b10 : (kind == 1) ? 2'b01 : ($urandom_range(0, 1) ? 2'b11 : 2'b00);
         cmd  = {2'b00, op, 2'b00, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))};
         if (kind == 2) pkt = '{8'h00, cmd};
         else pkt = '{8'h00, cmd, 8'($urandom), 8'($urandom), 8'(len)};
         if (kind == 0) for (int k = 0; k < len; k++) pkt.push_back(8'($urandom));
         run_packet($sformatf("rand%0d", p), -1, -1);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
